// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_timing_gen
//  Purpose  : Parametrised parallel-RGB LCD raster timing generator with
//             pixel-tick enable, prefetch strobe and clean start/stop control.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int PREFETCH = 2,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk__enable,
    input  logic          enable,
    output logic          running,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          display_enable,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic          pixel_request,
    output logic          line_start,
    output logic          frame_start
);

    localparam int c_H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    // One spare count of headroom so the active-window end bound always fits.
    localparam int c_HW = $clog2(c_H_TOTAL + 1);
    localparam int c_VW = $clog2(c_V_TOTAL + 1);

    localparam logic [c_HW-1:0] c_H_LAST = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_SYNC = c_HW'(H_SYNC);
    localparam logic [c_HW-1:0] c_HA0    = c_HW'(H_SYNC + H_BP);
    localparam logic [c_HW-1:0] c_HA1    = c_HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [c_HW-1:0] c_HR0    = c_HW'(H_SYNC + H_BP - PREFETCH);
    localparam logic [c_HW-1:0] c_HR1    = c_HW'(H_SYNC + H_BP + H_ACTIVE - PREFETCH);
    localparam logic [c_VW-1:0] c_V_LAST = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_SYNC = c_VW'(V_SYNC);
    localparam logic [c_VW-1:0] c_VA0    = c_VW'(V_SYNC + V_BP);
    localparam logic [c_VW-1:0] c_VA1    = c_VW'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [c_HW-1:0]   r_h;
    logic [c_VW-1:0]   r_v;
    logic [c_HW-1:0]   w_h_nx;
    logic [c_VW-1:0]   w_v_nx;
    logic [c_HW-1:0]   w_h_inc;
    logic [c_VW-1:0]   w_v_inc;
    logic              w_wrap;
    logic              w_line_pulse;
    logic              w_frame_pulse;

    assign w_h_inc = (r_h == c_H_LAST) ? '0 : r_h + 1'b1;
    assign w_v_inc = (r_h != c_H_LAST) ? r_v :
                     (r_v == c_V_LAST) ? '0  : r_v + 1'b1;
    assign w_wrap  = (r_h == c_H_LAST) && (r_v == c_V_LAST);

    always_comb begin
        w_state_nx    = r_state;
        w_h_nx        = r_h;
        w_v_nx        = r_v;
        w_line_pulse  = 1'b0;
        w_frame_pulse = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nx    = ST_RUN;
                    w_h_nx        = '0;
                    w_v_nx        = '0;
                    w_line_pulse  = 1'b1;
                    w_frame_pulse = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // A stop request only takes effect once the frame has finished.
                if (!enable && w_wrap) begin
                    w_state_nx = ST_IDLE;
                    w_h_nx     = '0;
                    w_v_nx     = '0;
                end else begin
                    w_state_nx    = enable ? ST_RUN : ST_DRAIN;
                    w_h_nx        = w_h_inc;
                    w_v_nx        = w_v_inc;
                    w_line_pulse  = (w_h_inc == '0);
                    w_frame_pulse = w_wrap;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_h_nx     = '0;
                w_v_nx     = '0;
            end
        endcase
    end

    logic            w_run_nx;
    logic            w_h_act;
    logic            w_v_act;
    logic            w_h_req;
    logic            w_de_nx;
    logic [c_HW-1:0] w_px_full;
    logic [c_VW-1:0] w_py_full;

    assign w_run_nx  = (w_state_nx != ST_IDLE);
    assign w_h_act   = (w_h_nx >= c_HA0) && (w_h_nx < c_HA1);
    assign w_v_act   = (w_v_nx >= c_VA0) && (w_v_nx < c_VA1);
    assign w_h_req   = (w_h_nx >= c_HR0) && (w_h_nx < c_HR1);
    assign w_de_nx   = w_run_nx && w_h_act && w_v_act;
    assign w_px_full = w_h_nx - c_HA0;
    assign w_py_full = w_v_nx - c_VA0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_h            <= '0;
            r_v            <= '0;
            running        <= 1'b0;
            hsync_n        <= 1'b1;
            vsync_n        <= 1'b1;
            display_enable <= 1'b0;
            pixel_x        <= '0;
            pixel_y        <= '0;
            pixel_request  <= 1'b0;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            // Pulses last one clk regardless of the tick pattern that follows.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (clk__enable) begin
                r_state        <= w_state_nx;
                r_h            <= w_h_nx;
                r_v            <= w_v_nx;
                running        <= w_run_nx;
                hsync_n        <= !(w_run_nx && (w_h_nx < c_H_SYNC));
                vsync_n        <= !(w_run_nx && (w_v_nx < c_V_SYNC));
                display_enable <= w_de_nx;
                pixel_x        <= w_de_nx ? XW'(w_px_full) : '0;
                pixel_y        <= w_de_nx ? YW'(w_py_full) : '0;
                pixel_request  <= w_run_nx && w_v_act && w_h_req;
                line_start     <= w_line_pulse;
                frame_start    <= w_frame_pulse;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised raster timing generator for parallel-RGB LCD panels. It produces hsync_n, vsync_n, display_enable, the active-pixel coordinates and a prefetch request from a single clock with a pixel-rate enable. It is the generalised successor to the fixed 480x272 LCD timing path: porches, sync widths, resolution and prefetch depth are parameters, and it adds clean start/stop control. It sits in the video clock domain between the PLL-derived video clock and the framebuffer fetch / pixel pipeline.

## Interface
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (ticks)
- H_SYNC, 41, hsync pulse width (ticks)
- H_BP, 2, horizontal back porch (ticks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, vsync pulse width (lines)
- V_BP, 2, vertical back porch (lines)
- PREFETCH, 2, ticks by which pixel_request leads display_enable; 0 ≤ PREFETCH ≤ H_SYNC+H_BP
- XW, 10, pixel_x width; YW, 9, pixel_y width (must hold H_ACTIVE-1, V_ACTIVE-1)
- clk  in  1  video clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- clk__enable  in  1  pixel tick; state advances only on edges where high
- enable  in  1  run request
- running  out  1  generator is producing frames
- hsync_n, vsync_n  out  1  active-low syncs
- display_enable  out  1  active pixel window
- pixel_x  out  XW  active column, 0 outside active window
- pixel_y  out  YW  active line, 0 outside active window
- pixel_request  out  1  fetch strobe, PREFETCH ticks ahead of display_enable
- line_start, frame_start  out  1  single-clk pulses

## Operation
- Decided: one clock; reset is synchronous and active-high.
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP. Counters h in [0,H_TOTAL), v in [0,V_TOTAL).
- Line order from h=0: sync [0,H_SYNC), back porch, active [HA0, HA0+H_ACTIVE) with HA0=H_SYNC+H_BP, front porch. Vertical identical in lines, VA0=V_SYNC+V_BP.
- hsync_n = !(h<H_SYNC); vsync_n = !(v<V_SYNC), changes at h wrap only; display_enable = h and v both active; pixel_x = h-HA0, pixel_y = v-VA0 when active, else 0.
- pixel_request = v active and h in [HA0-PREFETCH, HA0+H_ACTIVE-PREFETCH); PREFETCH=0 makes it equal display_enable. Never asserted for lines outside active region.
- h wraps H_TOTAL-1→0 and increments v; v wraps V_TOTAL-1→0.
- FSM: IDLE (counters 0, syncs high, all else 0) → RUN on tick with enable=1. RUN → DRAIN if enable=0 on a tick. DRAIN → RUN if enable returns to 1 before frame end; DRAIN → IDLE on the tick where h,v wrap to 0,0. Frames are never truncated by enable.
- running = 1 in RUN and DRAIN.
- line_start pulses when h becomes 0 in RUN/DRAIN, including first entry from IDLE; frame_start pulses when h,v both become 0 (coincident with line_start). Not pulsed on the DRAIN→IDLE wrap.

## Timing
- All outputs registered; they reflect the (h,v) loaded at the most recent tick edge and hold between ticks.
- Reset (any cycle, mid-frame included) → next edge: IDLE, h=v=0, hsync_n=1, vsync_n=1, display_enable=0, pixel_x=0, pixel_y=0, pixel_request=0, running=0, line_start=0, frame_start=0. reset overrides clk__enable.
- IDLE→RUN: tick with enable=1 loads h=v=0; same edge sets hsync_n=0, vsync_n=0, running=1, line_start=frame_start=1.
- line_start/frame_start high exactly one clk cycle even when clk__enable is held high for consecutive cycles or is low on the following cycle.
- clk__enable low: no state or output change except pulse deassertion.
- Defaults: 525 ticks/line, 286 lines/frame, 150150 ticks/frame (59.94 Hz at 9 MHz).

## Test plan
- Reset mid-frame with clk__enable=1 → all outputs at listed reset values next edge; running=0 until enable.
- Defaults, enable=1, clk__enable=1: hsync_n low 41 ticks of 525; display_enable high 480 ticks per line on 272 lines; vsync_n low 10×525 ticks; frame_start period 150150 cycles.
- clk__enable pulsed 1-in-3: all periods scale ×3; pulses stay one clk wide; pixel_x 0..479 monotonic.
- H_ACTIVE=4, H_SYNC=2, H_BP=2, H_FP=1, V_*=1/1/2/1, PREFETCH=2: pixel_request rises at h=2, falls at h=6; display_enable h=4..7; pixel_x 0,1,2,3 then 0.
- enable dropped at v=5 → frame completes, IDLE at wrap, running=0, no frame_start; re-raise during DRAIN → continuous frames, no gap.
- enable raised same edge as reset → reset wins; RUN entered on next tick.
